// File: rtl/fifo_main_pkg.sv
// Shared FIFO geometry and default flag thresholds, reused by the FIFOs in the switch.
package fifo_main_pkg;
  localparam int DFLT_DATA_WIDTH = 6;
  localparam int DFLT_ADDR_WIDTH = 2;
  localparam int DFLT_DEPTH      = 1 << DFLT_ADDR_WIDTH;
  localparam int DFLT_AF_THRESH  = 3;
  localparam int DFLT_AE_THRESH  = 1;
endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_WIDTH storage: synchronous write, registered synchronous read.
module fifo_ram
  import fifo_main_pkg::*;
#(
  parameter int DATA_WIDTH = DFLT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DFLT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)   rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo_main.sv
// Synchronous FIFO: self-generated pointers, occupancy count, level flags and sticky error.
module fifo_main
  import fifo_main_pkg::*;
#(
  parameter int DATA_WIDTH = DFLT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DFLT_ADDR_WIDTH,
  parameter int AF_THRESH  = DFLT_AF_THRESH,
  parameter int AE_THRESH  = DFLT_AE_THRESH
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  fifo_error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  pop_acc, push_acc;

  // A push into a full FIFO is legal only when a pop frees a slot on the same edge.
  assign pop_acc  = pop && !empty;
  assign push_acc = push && (!full || pop_acc);

  assign full         = (count == (ADDR_WIDTH+1)'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= (ADDR_WIDTH+1)'(AF_THRESH));
  assign almost_empty = (count <= (ADDR_WIDTH+1)'(AE_THRESH));

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      valid_out  <= 1'b0;
      fifo_error <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_acc, pop_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      valid_out <= pop_acc;
      if ((push && !push_acc) || (pop && !pop_acc)) fifo_error <= 1'b1;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .reset_L (reset_L),
    .wr_en   (push_acc),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_en   (pop_acc),
    .rd_addr (rd_ptr),
    .rd_data (data_out)
  );

endmodule

// File: tb/tb_fifo_main.sv
// Scoreboard bench for fifo_main: directed push/pop vectors, monitor checks popped words.
module tb_fifo_main;
  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic       push = 1'b0;
  logic [5:0] data_in = '0;
  logic       pop = 1'b0;
  logic [5:0] data_out;
  logic       valid_out;
  logic [2:0] count;
  logic       full, empty, almost_full, almost_empty, fifo_error;

  int checks = 0;
  int failures = 0;

  logic [5:0] model_q[$];
  logic [5:0] exp_q[$];
  bit         m_err = 1'b0;

  always #5 clk = ~clk;

  fifo_main dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fifo_error   (fifo_error)
  );

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: every presented word must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_L && valid_out) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        chk("data_out", int'(data_out), int'(e));
      end
    end
  end

  task automatic check_flags(input string tag);
    int n;
    n = model_q.size();
    chk({tag, "_count"}, int'(count), n);
    chk({tag, "_full"}, int'(full), int'(n == 4));
    chk({tag, "_empty"}, int'(empty), int'(n == 0));
    chk({tag, "_afull"}, int'(almost_full), int'(n >= 3));
    chk({tag, "_aempty"}, int'(almost_empty), int'(n <= 1));
    chk({tag, "_err"}, int'(fifo_error), int'(m_err));
  endtask

  task automatic step(input logic p, input logic [5:0] d, input logic q, input string tag);
    bit pa, ua;
    push = p; data_in = d; pop = q;
    pa = q && (model_q.size() > 0);
    ua = p && ((model_q.size() < 4) || pa);
    if ((p && !ua) || (q && !pa)) m_err = 1'b1;
    if (pa) exp_q.push_back(model_q.pop_front());
    if (ua) model_q.push_back(d);
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
    check_flags(tag);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_empty"}, int'(empty), 1);
    chk({tag, "_aempty"}, int'(almost_empty), 1);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_afull"}, int'(almost_full), 0);
    chk({tag, "_err"}, int'(fifo_error), 0);
    chk({tag, "_valid"}, int'(valid_out), 0);
    chk({tag, "_dout"}, int'(data_out), 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk); #2;
    reset_L = 1'b0;
    #1;
    check_reset_values(tag);
    model_q.delete();
    exp_q.delete();
    m_err = 1'b0;
    @(negedge clk);
    reset_L = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    // Power-on reset
    #12;
    check_reset_values("por");
    @(negedge clk);
    reset_L = 1'b1;
    @(posedge clk); #1;

    // Fill 1..4
    for (int i = 1; i <= 4; i++) step(1'b1, 6'(i), 1'b0, "fill");
    chk("fill_full_hand", int'(full), 1);
    chk("fill_count_hand", int'(count), 4);
    chk("fill_err_hand", int'(fifo_error), 0);

    // Drain four: scoreboard expects 1,2,3,4
    for (int i = 0; i < 4; i++) step(1'b0, 6'h0, 1'b1, "drain");
    step(1'b0, 6'h0, 1'b0, "idle");
    chk("drain_empty_hand", int'(empty), 1);
    chk("drain_outstanding", exp_q.size(), 0);

    // Overflow: fifth push rejected, error sticks
    for (int i = 11; i <= 15; i++) step(1'b1, 6'(i), 1'b0, "ovf");
    chk("ovf_count_hand", int'(count), 4);
    chk("ovf_err_hand", int'(fifo_error), 1);
    step(1'b0, 6'h0, 1'b0, "ovf_hold");
    chk("ovf_err_sticky", int'(fifo_error), 1);

    do_reset("rst1");

    // Full with simultaneous push/pop, pointers wrap, no error
    for (int i = 31; i <= 34; i++) step(1'b1, 6'(i), 1'b0, "fill2");
    for (int i = 21; i <= 26; i++) step(1'b1, 6'(i), 1'b1, "both");
    chk("both_count_hand", int'(count), 4);
    chk("both_err_hand", int'(fifo_error), 0);
    for (int i = 0; i < 4; i++) step(1'b0, 6'h0, 1'b1, "drain2");
    step(1'b0, 6'h0, 1'b0, "idle2");

    // Pop on empty with push: pop rejected, push stored, no bypass
    step(1'b1, 6'h2A, 1'b1, "pe");
    chk("pe_count_hand", int'(count), 1);
    chk("pe_err_hand", int'(fifo_error), 1);
    chk("pe_valid_hand", int'(valid_out), 0);
    step(1'b0, 6'h0, 1'b1, "pe_pop");
    step(1'b0, 6'h0, 1'b0, "idle3");
    chk("pe_outstanding", exp_q.size(), 0);

    // Async reset mid-operation with data held
    step(1'b1, 6'h07, 1'b0, "pre_rst");
    step(1'b1, 6'h08, 1'b0, "pre_rst");
    #2;
    reset_L = 1'b0;
    #1;
    check_reset_values("async_rst");
    model_q.delete();
    m_err = 1'b0;
    @(negedge clk);
    reset_L = 1'b1;
    step(1'b0, 6'h0, 1'b1, "post_rst_pop");
    chk("post_rst_valid", int'(valid_out), 0);
    step(1'b0, 6'h0, 1'b0, "idle4");
    step(1'b0, 6'h0, 1'b0, "idle5");
    chk("final_outstanding", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
